// File: rtl/button_conditioner.sv
// Push-button conditioner: per-button 2-FF synchroniser and saturating debounce counter,
// followed by press-edge detection and a priority-encoded direction event.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic       dir_valid,
  output logic [1:0] dir_code,
  output logic       press_dropped
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]                raw;
  logic [3:0]                sync1_q, sync2_q;
  logic [3:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]                level_q, level_d;
  logic [3:0]                press_q, press_d;
  logic                      valid_q, valid_d;
  logic [1:0]                code_q, code_d;
  logic                      dropped_q, dropped_d;

  assign raw = {btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};

  // Only sync2_q feeds the debounce logic; raw pins are never used directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle of agreement clears the count, so only an unbroken run is accepted.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    press_d   = level_d & ~level_q;
    valid_d   = |press_d;
    dropped_d = (press_d & (press_d - 4'd1)) != 4'd0;
    code_d    = code_q;
    if (press_d[0]) begin
      code_d = 2'd0;
    end else if (press_d[1]) begin
      code_d = 2'd1;
    end else if (press_d[2]) begin
      code_d = 2'd2;
    end else if (press_d[3]) begin
      code_d = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      valid_q   <= 1'b0;
      code_q    <= 2'd0;
      dropped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      dropped_q <= dropped_d;
    end
  end

  assign btn_level     = level_q;
  assign btn_press     = press_q;
  assign dir_valid     = valid_q;
  assign dir_code      = code_q;
  assign press_dropped = dropped_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner, checked against a window-based
// reference model: a level is accepted once the last DEB synchronised samples all disagree.
module tb_button_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw = 4'd0;
  logic [3:0] btn_level, btn_press;
  logic       dir_valid, press_dropped;
  logic [1:0] dir_code;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit [3:0] m_s1, m_s2;
  bit       hist [4][DEB];
  int       filled [4];
  bit [3:0] m_level, m_press;
  bit       m_valid, m_drop;
  bit [1:0] m_code;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up_raw   (raw[0]),
    .btn_down_raw (raw[1]),
    .btn_left_raw (raw[2]),
    .btn_right_raw(raw[3]),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .dir_valid    (dir_valid),
    .dir_code     (dir_code),
    .press_dropped(press_dropped)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit [3:0] r);
    bit [3:0] eff, nxt;
    bit       all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
      m_valid = 0; m_drop = 0; m_code = '0;
      for (int b = 0; b < 4; b++) filled[b] = 0;
      return;
    end
    eff  = m_s2;
    m_s2 = m_s1;
    m_s1 = r;
    nxt  = m_level;
    for (int b = 0; b < 4; b++) begin
      for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = eff[b];
      if (filled[b] < DEB) filled[b]++;
      all_diff = (filled[b] == DEB);
      for (int k = 0; k < DEB; k++) if (hist[b][k] == m_level[b]) all_diff = 0;
      if (all_diff) nxt[b] = eff[b];
    end
    m_press = nxt & ~m_level;
    m_valid = (m_press != 0);
    m_drop  = ($countones(m_press) > 1);
    for (int b = 3; b >= 0; b--) if (m_press[b]) m_code = 2'(b);
    m_level = nxt;
  endtask

  task automatic cycle(input bit rst, input bit [3:0] r);
    @(negedge clk);
    reset = rst;
    raw   = r;
    @(posedge clk);
    model_step(rst, r);
    #1;
    check_val("level", 32'(btn_level), 32'(m_level));
    check_val("press", 32'(btn_press), 32'(m_press));
    check_val("valid", 32'(dir_valid), 32'(m_valid));
    check_val("code", 32'(dir_code), 32'(m_code));
    check_val("dropped", 32'(press_dropped), 32'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'd0);
  endtask

  initial begin
    int       hold_left [4];
    bit [3:0] cur;
    bit       rst;

    // Reset held with all buttons pressed
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'hF);
      check_val("rst_level", 32'(btn_level), 32'd0);
      check_val("rst_press", 32'(btn_press), 32'd0);
    end
    for (int n = 1; n <= 6; n++) begin
      cycle(0, 4'hF);
      if (n == 5) check_val("rst_nopulse5", 32'(btn_press), 32'd0);
    end
    check_val("rst_press6", 32'(btn_press), 32'hF);
    check_val("rst_valid6", 32'(dir_valid), 32'd1);
    check_val("rst_code6", 32'(dir_code), 32'd0);
    check_val("rst_drop6", 32'(press_dropped), 32'd1);
    idle(10);

    // Clean press of up
    for (int k = 0; k <= 6; k++) begin
      cycle(0, 4'b0001);
      if (k == 4) check_val("up_early", 32'(btn_level), 32'd0);
      if (k == 5) begin
        check_val("up_press", 32'(btn_press), 32'b0001);
        check_val("up_valid", 32'(dir_valid), 32'd1);
        check_val("up_code", 32'(dir_code), 32'd0);
      end
      if (k == 6) check_val("up_once", 32'(btn_press), 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      cycle(0, 4'd0);
      check_val("up_release", 32'(btn_press), 32'd0);
    end

    // Glitchy left never accepted
    for (int k = 0; k < 15; k++) begin
      cycle(0, (k < 3 || (k >= 4 && k < 7)) ? 4'b0100 : 4'b0000);
      check_val("glitch_level", 32'(btn_level), 32'd0);
      check_val("glitch_valid", 32'(dir_valid), 32'd0);
    end

    // Simultaneous down + right
    for (int k = 0; k <= 6; k++) begin
      cycle(0, 4'b1010);
      if (k == 5) begin
        check_val("sim_press", 32'(btn_press), 32'b1010);
        check_val("sim_code", 32'(dir_code), 32'd1);
        check_val("sim_drop", 32'(press_dropped), 32'd1);
      end
    end
    idle(10);

    // Staggered right then left
    for (int k = 0; k <= 9; k++) begin
      cycle(0, (k >= 2) ? 4'b1100 : 4'b1000);
      check_val("stag_drop", 32'(press_dropped), 32'd0);
      if (k == 5) begin
        check_val("stag_valid5", 32'(dir_valid), 32'd1);
        check_val("stag_code5", 32'(dir_code), 32'd3);
      end
      if (k == 6) check_val("stag_code_hold", 32'(dir_code), 32'd3);
      if (k == 7) begin
        check_val("stag_valid7", 32'(dir_valid), 32'd1);
        check_val("stag_code7", 32'(dir_code), 32'd2);
      end
    end
    idle(10);

    // Reset in the middle of a count
    for (int k = 0; k < 3; k++) cycle(0, 4'b0001);
    cycle(1, 4'b0001);
    for (int n = 1; n <= 6; n++) begin
      cycle(0, 4'b0001);
      if (n == 2) check_val("midrst_e5", 32'(btn_press), 32'd0);
      if (n == 5) check_val("midrst_n5", 32'(btn_press), 32'd0);
    end
    check_val("midrst_n6", 32'(btn_press), 32'b0001);
    idle(10);

    // Random slowly-varying buttons with occasional reset
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          cur[b]       = 1'($urandom_range(0, 1));
          hold_left[b] = $urandom_range(1, 8);
        end
        hold_left[b]--;
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle(rst, cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
